// File: rtl/apb_lsu.sv
// APB master load/store unit: one request at a time from the core, run as an
// APB SETUP/ACCESS transfer with byte-lane steering, load extension,
// misalignment detection and a wait-state timeout reported as a typed error.
//
// state  | meaning
// IDLE   | ready for a request
// SETUP  | APB setup phase (psel=1, penable=0)
// ACCESS | APB access phase, waiting for pready or timeout
// RESP   | response held until the core takes it
module apb_lsu #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 255
) (
  input  logic                    clk,
  input  logic                    rts_n,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_write,
  input  logic [1:0]              req_size,
  input  logic                    req_unsigned,
  input  logic [ADDR_WIDTH-1:0]   req_addr,
  input  logic [DATA_WIDTH-1:0]   req_wdata,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic [1:0]              rsp_err,
  output logic [ADDR_WIDTH-1:0]   APB_paddr,
  output logic [DATA_WIDTH-1:0]   APB_pdata,
  input  logic [DATA_WIDTH-1:0]   APB_prdata,
  output logic                    APB_psel,
  output logic                    APB_penable,
  output logic                    APB_pwrite,
  output logic [DATA_WIDTH/8-1:0] APB_pstb,
  input  logic                    APB_pready,
  input  logic                    APB_perr
);

  localparam int NB = DATA_WIDTH / 8;
  localparam int OW = $clog2(NB);
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  localparam logic [1:0] ERR_OK      = 2'b00;
  localparam logic [1:0] ERR_ALIGN   = 2'b01;
  localparam logic [1:0] ERR_BUS     = 2'b10;
  localparam logic [1:0] ERR_TIMEOUT = 2'b11;

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACCESS, S_RESP} state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
  logic [DATA_WIDTH-1:0] pdata_q, pdata_d;
  logic [NB-1:0]         pstb_q, pstb_d;
  logic                  write_q, write_d;
  logic                  uns_q, uns_d;
  logic [1:0]            size_q, size_d;
  logic [OW-1:0]         off_q, off_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [1:0]            err_q, err_d;
  logic [CW-1:0]         cnt_q, cnt_d;

  logic [OW-1:0]         req_off;
  logic [OW-1:0]         size_mask;
  logic                  req_bad;
  logic [NB-1:0]         req_strb;
  logic [DATA_WIDTH-1:0] shifted;
  logic                  sign_bit;
  logic [DATA_WIDTH-1:0] load_data;
  logic                  to_hit;

  // Decode the incoming request: lane offset, alignment and write strobes.
  always_comb begin
    req_off   = req_addr[OW-1:0];
    size_mask = OW'((32'd1 << req_size) - 32'd1);
    req_bad   = (|(req_off & size_mask)) || ((req_size == 2'd3) && (DATA_WIDTH == 32));
    req_strb  = NB'(((32'd1 << (32'd1 << req_size)) - 32'd1) << req_off);
  end

  // Pull the addressed bytes down to bit 0 and extend to the full bus width.
  always_comb begin
    shifted = APB_prdata >> {off_q, 3'b000};
    case (size_q)
      2'd0:    sign_bit = shifted[7];
      2'd1:    sign_bit = shifted[15];
      2'd2:    sign_bit = shifted[31];
      default: sign_bit = shifted[DATA_WIDTH-1];
    endcase
    sign_bit  = sign_bit & ~uns_q;
    load_data = '0;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      load_data[i] = (i < (8 << size_q)) ? shifted[i] : sign_bit;
    end
  end

  // Timer is a down-counter loaded with TIMEOUT on entry to ACCESS; reaching
  // one on a cycle without pready means this is the last allowed ACCESS cycle.
  assign to_hit = (TIMEOUT != 0) && (cnt_q == CW'(1));

  // Next-state and datapath update.
  always_comb begin
    state_d = state_q;
    paddr_d = paddr_q;
    pdata_d = pdata_q;
    pstb_d  = pstb_q;
    write_d = write_q;
    uns_d   = uns_q;
    size_d  = size_q;
    off_d   = off_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          paddr_d = {req_addr[ADDR_WIDTH-1:OW], {OW{1'b0}}};
          pdata_d = req_wdata << {req_off, 3'b000};
          pstb_d  = req_write ? req_strb : '1;
          write_d = req_write;
          uns_d   = req_unsigned;
          size_d  = req_size;
          off_d   = req_off;
          if (req_bad) begin
            err_d   = ERR_ALIGN;
            rdata_d = '0;
            state_d = S_RESP;
          end else begin
            state_d = S_SETUP;
          end
        end
      end
      S_SETUP: begin
        cnt_d   = CW'(TIMEOUT);
        state_d = S_ACCESS;
      end
      S_ACCESS: begin
        if (APB_pready) begin
          state_d = S_RESP;
          if (APB_perr) begin
            err_d   = ERR_BUS;
            rdata_d = '0;
          end else begin
            err_d   = ERR_OK;
            rdata_d = write_q ? '0 : load_data;
          end
        end else if (to_hit) begin
          state_d = S_RESP;
          err_d   = ERR_TIMEOUT;
          rdata_d = '0;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_RESP: begin
        if (rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rts_n) begin
      state_q <= S_IDLE;
      paddr_q <= '0;
      pdata_q <= '0;
      pstb_q  <= '1;
      write_q <= 1'b0;
      uns_q   <= 1'b0;
      size_q  <= 2'd0;
      off_q   <= '0;
      rdata_q <= '0;
      err_q   <= ERR_OK;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      paddr_q <= paddr_d;
      pdata_q <= pdata_d;
      pstb_q  <= pstb_d;
      write_q <= write_d;
      uns_q   <= uns_d;
      size_q  <= size_d;
      off_q   <= off_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  assign req_ready   = (state_q == S_IDLE);
  assign rsp_valid   = (state_q == S_RESP);
  assign rsp_rdata   = rdata_q;
  assign rsp_err     = err_q;
  assign APB_psel    = (state_q == S_SETUP) || (state_q == S_ACCESS);
  assign APB_penable = (state_q == S_ACCESS);
  assign APB_pwrite  = write_q;
  assign APB_paddr   = paddr_q;
  assign APB_pdata   = pdata_q;
  assign APB_pstb    = pstb_q;

endmodule

// File: tb/tb_apb_lsu.sv
// Bench for apb_lsu: a 32-bit instance with TIMEOUT=4 and a 64-bit instance
// with the default timeout, sharing clock and reset.
module tb_apb_lsu;

  logic clk = 1'b0;
  logic rts_n;
  always #5 clk = ~clk;

  // 32-bit instance
  logic        a_req_valid, a_req_ready, a_req_write, a_req_unsigned;
  logic [1:0]  a_req_size;
  logic [31:0] a_req_addr, a_req_wdata;
  logic        a_rsp_valid, a_rsp_ready;
  logic [31:0] a_rsp_rdata;
  logic [1:0]  a_rsp_err;
  logic [31:0] a_paddr, a_pdata, a_prdata;
  logic        a_psel, a_penable, a_pwrite, a_pready, a_perr;
  logic [3:0]  a_pstb;

  // 64-bit instance
  logic        b_req_valid, b_req_ready, b_req_write, b_req_unsigned;
  logic [1:0]  b_req_size;
  logic [31:0] b_req_addr;
  logic [63:0] b_req_wdata;
  logic        b_rsp_valid, b_rsp_ready;
  logic [63:0] b_rsp_rdata;
  logic [1:0]  b_rsp_err;
  logic [31:0] b_paddr;
  logic [63:0] b_pdata, b_prdata;
  logic        b_psel, b_penable, b_pwrite, b_pready, b_perr;
  logic [7:0]  b_pstb;

  apb_lsu #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT(4)) u_a (
    .clk(clk), .rts_n(rts_n),
    .req_valid(a_req_valid), .req_ready(a_req_ready), .req_write(a_req_write),
    .req_size(a_req_size), .req_unsigned(a_req_unsigned), .req_addr(a_req_addr),
    .req_wdata(a_req_wdata), .rsp_valid(a_rsp_valid), .rsp_ready(a_rsp_ready),
    .rsp_rdata(a_rsp_rdata), .rsp_err(a_rsp_err),
    .APB_paddr(a_paddr), .APB_pdata(a_pdata), .APB_prdata(a_prdata),
    .APB_psel(a_psel), .APB_penable(a_penable), .APB_pwrite(a_pwrite),
    .APB_pstb(a_pstb), .APB_pready(a_pready), .APB_perr(a_perr)
  );

  apb_lsu #(.ADDR_WIDTH(32), .DATA_WIDTH(64), .TIMEOUT(255)) u_b (
    .clk(clk), .rts_n(rts_n),
    .req_valid(b_req_valid), .req_ready(b_req_ready), .req_write(b_req_write),
    .req_size(b_req_size), .req_unsigned(b_req_unsigned), .req_addr(b_req_addr),
    .req_wdata(b_req_wdata), .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready),
    .rsp_rdata(b_rsp_rdata), .rsp_err(b_rsp_err),
    .APB_paddr(b_paddr), .APB_pdata(b_pdata), .APB_prdata(b_prdata),
    .APB_psel(b_psel), .APB_penable(b_penable), .APB_pwrite(b_pwrite),
    .APB_pstb(b_pstb), .APB_pready(b_pready), .APB_perr(b_perr)
  );

  typedef struct {
    logic [63:0] rdata;
    logic [1:0]  err;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic test_reset();
    rts_n = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    n_checks++;
    if ({a_psel, a_penable, a_pwrite, a_paddr, a_pdata, a_pstb, a_rsp_valid, a_rsp_rdata, a_rsp_err, a_req_ready}
        !== {1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'hF, 1'b0, 32'h0, 2'b00, 1'b1})
      $display("FAIL reset_a got psel=%b pen=%b pw=%b paddr=%h pdata=%h pstb=%b rv=%b rd=%h err=%b rr=%b want 0 0 0 0 0 1111 0 0 00 1",
               a_psel, a_penable, a_pwrite, a_paddr, a_pdata, a_pstb, a_rsp_valid, a_rsp_rdata, a_rsp_err, a_req_ready);
    else n_pass++;
    n_checks++;
    if ({b_psel, b_penable, b_pwrite, b_paddr, b_pdata, b_pstb, b_rsp_valid, b_rsp_rdata, b_rsp_err}
        !== {1'b0, 1'b0, 1'b0, 32'h0, 64'h0, 8'hFF, 1'b0, 64'h0, 2'b00})
      $display("FAIL reset_b got psel=%b pen=%b pw=%b paddr=%h pdata=%h pstb=%b rv=%b rd=%h err=%b want 0 0 0 0 0 ff 0 0 00",
               b_psel, b_penable, b_pwrite, b_paddr, b_pdata, b_pstb, b_rsp_valid, b_rsp_rdata, b_rsp_err);
    else n_pass++;
    rts_n = 1'b1;
    @(posedge clk); #1;
  endtask

  // Full transaction on the 32-bit instance; the slave answers after `waits`
  // low-pready cycles, and the response is held `hold` cycles before rsp_ready.
  task automatic a_txn(input string name, input logic wr, input logic [1:0] sz, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wd, input int waits,
                       input logic [31:0] rd, input logic perr, input logic apb,
                       input logic [31:0] e_paddr, input logic [31:0] e_pdata, input logic [3:0] e_pstb,
                       input logic [31:0] e_rdata, input logic [1:0] e_err, input int hold);
    exp_t e, got;
    e.rdata = {32'h0, e_rdata};
    e.err   = e_err;
    sb_q.push_back(e);
    a_req_write = wr; a_req_size = sz; a_req_unsigned = uns;
    a_req_addr = addr; a_req_wdata = wd; a_req_valid = 1'b1;
    n_checks++;
    if (a_req_ready !== 1'b1) $display("FAIL %s req_ready got %b want 1", name, a_req_ready);
    else n_pass++;
    @(posedge clk); #1;
    a_req_valid = 1'b0;
    if (apb) begin
      n_checks++;
      if ({a_psel, a_penable, a_pwrite, a_pstb, a_paddr, a_pdata} !== {1'b1, 1'b0, wr, e_pstb, e_paddr, e_pdata})
        $display("FAIL %s setup got psel=%b pen=%b pw=%b pstb=%b paddr=%h pdata=%h want 1 0 %b %b %h %h",
                 name, a_psel, a_penable, a_pwrite, a_pstb, a_paddr, a_pdata, wr, e_pstb, e_paddr, e_pdata);
      else n_pass++;
      @(posedge clk); #1;
      for (int k = 0; k <= waits; k++) begin
        n_checks++;
        if ({a_psel, a_penable, a_pwrite, a_pstb, a_paddr, a_pdata} !== {1'b1, 1'b1, wr, e_pstb, e_paddr, e_pdata})
          $display("FAIL %s access%0d got psel=%b pen=%b pw=%b pstb=%b paddr=%h pdata=%h want 1 1 %b %b %h %h",
                   name, k, a_psel, a_penable, a_pwrite, a_pstb, a_paddr, a_pdata, wr, e_pstb, e_paddr, e_pdata);
        else n_pass++;
        a_pready = (k == waits);
        a_perr   = (k == waits) ? perr : 1'b1;
        a_prdata = rd;
        @(posedge clk); #1;
      end
      a_pready = 1'b0;
      a_perr   = 1'b0;
    end else begin
      n_checks++;
      if (a_psel !== 1'b0) $display("FAIL %s no_apb psel got %b want 0", name, a_psel);
      else n_pass++;
    end
    n_checks++;
    if (a_rsp_valid !== 1'b1) $display("FAIL %s rsp_valid got %b want 1", name, a_rsp_valid);
    else n_pass++;
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      n_checks++;
      if ({a_rsp_valid, a_req_ready, a_rsp_rdata, a_rsp_err} !== {1'b1, 1'b0, e_rdata, e_err})
        $display("FAIL %s hold%0d got rv=%b rr=%b rd=%h err=%b want 1 0 %h %b",
                 name, h, a_rsp_valid, a_req_ready, a_rsp_rdata, a_rsp_err, e_rdata, e_err);
      else n_pass++;
    end
    got = sb_q.pop_front();
    n_checks++;
    if ({32'h0, a_rsp_rdata} !== got.rdata || a_rsp_err !== got.err)
      $display("FAIL %s rsp got rdata=%h err=%b want rdata=%h err=%b", name, a_rsp_rdata, a_rsp_err, got.rdata, got.err);
    else n_pass++;
    a_rsp_ready = 1'b1;
    @(posedge clk); #1;
    a_rsp_ready = 1'b0;
    n_checks++;
    if ({a_req_ready, a_rsp_valid} !== 2'b10)
      $display("FAIL %s release got req_ready=%b rsp_valid=%b want 1 0", name, a_req_ready, a_rsp_valid);
    else n_pass++;
  endtask

  task automatic test_store_word();
    a_txn("store_word", 1'b1, 2'd2, 1'b0, 32'h80000004, 32'hDEADBEEF, 0, 32'h0, 1'b0, 1'b1,
          32'h80000004, 32'hDEADBEEF, 4'b1111, 32'h0, 2'b00, 0);
  endtask

  task automatic test_load_byte();
    a_txn("load_byte_s", 1'b0, 2'd0, 1'b0, 32'h80000003, 32'h0, 0, 32'h80FF1234, 1'b0, 1'b1,
          32'h80000000, 32'h0, 4'b1111, 32'hFFFFFF80, 2'b00, 0);
    a_txn("load_byte_u", 1'b0, 2'd0, 1'b1, 32'h80000003, 32'h0, 0, 32'h80FF1234, 1'b0, 1'b1,
          32'h80000000, 32'h0, 4'b1111, 32'h00000080, 2'b00, 0);
  endtask

  task automatic test_store_half();
    a_txn("store_half", 1'b1, 2'd1, 1'b0, 32'h80000002, 32'h0000ABCD, 0, 32'h0, 1'b0, 1'b1,
          32'h80000000, 32'hABCD0000, 4'b1100, 32'h0, 2'b00, 0);
  endtask

  task automatic test_misaligned();
    a_txn("misalign_half", 1'b0, 2'd1, 1'b0, 32'h80000001, 32'h0, 0, 32'h0, 1'b0, 1'b0,
          32'h0, 32'h0, 4'h0, 32'h0, 2'b01, 0);
    a_txn("dword_on_32", 1'b0, 2'd3, 1'b0, 32'h80000000, 32'h0, 0, 32'h0, 1'b0, 1'b0,
          32'h0, 32'h0, 4'h0, 32'h0, 2'b01, 0);
  endtask

  task automatic test_bus_error();
    a_txn("bus_error", 1'b0, 2'd2, 1'b0, 32'h80000008, 32'h0, 0, 32'h12345678, 1'b1, 1'b1,
          32'h80000008, 32'h0, 4'b1111, 32'h0, 2'b10, 0);
  endtask

  task automatic test_wait_states();
    a_txn("wait_half_s", 1'b0, 2'd1, 1'b0, 32'h80000002, 32'h0, 2, 32'h80010000, 1'b0, 1'b1,
          32'h80000000, 32'h0, 4'b1111, 32'hFFFF8001, 2'b00, 0);
  endtask

  task automatic test_resp_hold();
    a_txn("resp_hold", 1'b0, 2'd2, 1'b1, 32'h8000000C, 32'h0, 0, 32'hCAFEF00D, 1'b0, 1'b1,
          32'h8000000C, 32'h0, 4'b1111, 32'hCAFEF00D, 2'b00, 3);
  endtask

  task automatic test_timeout();
    exp_t e, got;
    int   cyc = 1;
    int   psel_cycles = 0;
    e.rdata = 64'h0;
    e.err   = 2'b11;
    sb_q.push_back(e);
    a_req_write = 1'b0; a_req_size = 2'd2; a_req_unsigned = 1'b0;
    a_req_addr = 32'h80000010; a_req_wdata = 32'h0; a_req_valid = 1'b1;
    a_pready = 1'b0; a_perr = 1'b0; a_prdata = 32'h55555555;
    @(posedge clk); #1;
    a_req_valid = 1'b0;
    while (a_rsp_valid !== 1'b1 && cyc < 30) begin
      if (a_psel === 1'b1) psel_cycles++;
      @(posedge clk); #1;
      cyc++;
    end
    n_checks++;
    if (a_rsp_valid !== 1'b1) $display("FAIL timeout rsp_valid got %b want 1 within 30 cycles", a_rsp_valid);
    else n_pass++;
    n_checks++;
    if (psel_cycles != 5) $display("FAIL timeout psel_cycles got %0d want 5", psel_cycles);
    else n_pass++;
    got = sb_q.pop_front();
    n_checks++;
    if ({32'h0, a_rsp_rdata} !== got.rdata || a_rsp_err !== got.err)
      $display("FAIL timeout rsp got rdata=%h err=%b want rdata=%h err=%b", a_rsp_rdata, a_rsp_err, got.rdata, got.err);
    else n_pass++;
    a_rsp_ready = 1'b1;
    @(posedge clk); #1;
    a_rsp_ready = 1'b0;
  endtask

  task automatic test_dword64();
    exp_t e, got;
    int   cyc = 1;
    e.rdata = 64'h8000000000000001;
    e.err   = 2'b00;
    sb_q.push_back(e);
    b_req_write = 1'b0; b_req_size = 2'd3; b_req_unsigned = 1'b0;
    b_req_addr = 32'h00000010; b_req_wdata = 64'h0; b_req_valid = 1'b1;
    b_prdata = 64'h8000000000000001; b_pready = 1'b0; b_perr = 1'b0;
    n_checks++;
    if (b_req_ready !== 1'b1) $display("FAIL dword64 req_ready got %b want 1", b_req_ready);
    else n_pass++;
    @(posedge clk); #1;
    b_req_valid = 1'b0;
    n_checks++;
    if ({b_psel, b_penable, b_pwrite, b_pstb, b_paddr} !== {1'b1, 1'b0, 1'b0, 8'hFF, 32'h10})
      $display("FAIL dword64 setup got psel=%b pen=%b pw=%b pstb=%h paddr=%h want 1 0 0 ff 00000010",
               b_psel, b_penable, b_pwrite, b_pstb, b_paddr);
    else n_pass++;
    while (b_rsp_valid !== 1'b1 && cyc < 20) begin
      b_pready = (cyc == 5);
      @(posedge clk); #1;
      cyc++;
    end
    b_pready = 1'b0;
    n_checks++;
    if (cyc != 6 || b_rsp_valid !== 1'b1)
      $display("FAIL dword64 rsp_cycle got %0d (rv=%b) want 6", cyc, b_rsp_valid);
    else n_pass++;
    got = sb_q.pop_front();
    n_checks++;
    if (b_rsp_rdata !== got.rdata || b_rsp_err !== got.err)
      $display("FAIL dword64 rsp got rdata=%h err=%b want rdata=%h err=%b", b_rsp_rdata, b_rsp_err, got.rdata, got.err);
    else n_pass++;
    b_rsp_ready = 1'b1;
    @(posedge clk); #1;
    b_rsp_ready = 1'b0;
  endtask

  task automatic test_mid_reset();
    a_req_write = 1'b1; a_req_size = 2'd2; a_req_unsigned = 1'b0;
    a_req_addr = 32'h80000020; a_req_wdata = 32'h01234567; a_req_valid = 1'b1;
    a_pready = 1'b0; a_perr = 1'b0;
    @(posedge clk); #1;
    a_req_valid = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if ({a_psel, a_penable} !== 2'b11) $display("FAIL mid_reset in_access got psel=%b pen=%b want 1 1", a_psel, a_penable);
    else n_pass++;
    rts_n = 1'b0;
    @(posedge clk); #1;
    rts_n = 1'b1;
    n_checks++;
    if ({a_psel, a_penable, a_rsp_valid} !== 3'b000)
      $display("FAIL mid_reset after got psel=%b pen=%b rv=%b want 0 0 0", a_psel, a_penable, a_rsp_valid);
    else n_pass++;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      n_checks++;
      if ({a_req_ready, a_rsp_valid, a_psel} !== 3'b100)
        $display("FAIL mid_reset idle%0d got rr=%b rv=%b psel=%b want 1 0 0", c, a_req_ready, a_rsp_valid, a_psel);
      else n_pass++;
    end
  endtask

  initial begin
    rts_n = 1'b0;
    a_req_valid = 1'b0; a_req_write = 1'b0; a_req_size = 2'd0; a_req_unsigned = 1'b0;
    a_req_addr = 32'h0; a_req_wdata = 32'h0; a_rsp_ready = 1'b0;
    a_prdata = 32'h0; a_pready = 1'b0; a_perr = 1'b0;
    b_req_valid = 1'b0; b_req_write = 1'b0; b_req_size = 2'd0; b_req_unsigned = 1'b0;
    b_req_addr = 32'h0; b_req_wdata = 64'h0; b_rsp_ready = 1'b0;
    b_prdata = 64'h0; b_pready = 1'b0; b_perr = 1'b0;
    #2;
    test_reset();
    test_store_word();
    test_load_byte();
    test_store_half();
    test_misaligned();
    test_bus_error();
    test_wait_states();
    test_resp_hold();
    test_timeout();
    test_dword64();
    test_mid_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog simulation did not finish within time limit");
    $fatal(1);
  end

endmodule
